// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared constants and the loader FSM state type for the instruction memory
// program loader.
//   DEPTH   : number of instruction words; a count byte of 0 means DEPTH
//   ADDR_W  : instruction memory address width
//   DATA_W  : instruction word width
//   CSUM_W  : width of the XOR checksum accumulator
//   WCNT_W  : word counter width (one bit wider than ADDR_W so 256 fits)
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CSUM_W = 8;
    localparam int WCNT_W = 9;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_COUNT = 4'd1,
        S_HI    = 4'd2,
        S_LO    = 4'd3,
        S_WRITE = 4'd4,
        S_CHECK = 4'd5,
        S_DONE  = 4'd6,
        S_ERROR = 4'd7
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's byte stream handshake, instruction memory write port
// and status signals.
//   Load_Req            : start-of-load request (host -> loader)
//   In_Data/In_Valid    : stream byte and its valid (host -> loader)
//   In_Ready            : loader accepts a byte this cycle (loader -> host)
//   Mem_Wr/Addr/Data    : instruction memory write port (loader -> memory)
//   CPU_Hold            : processor reset hold
//   Done / Error        : completion pulse / checksum failure level
//   State               : FSM state for debug
// Modports: slave = the loader, master = the host/stream source side.
// -----------------------------------------------------------------------------
interface imem_loader_if;
    import loader_pkg::*;

    logic              Load_Req;
    logic [7:0]        In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic              Mem_Wr;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Data;
    logic              CPU_Hold;
    logic              Done;
    logic              Error;
    logic [3:0]        State;

    modport slave (
        input  Load_Req, In_Data, In_Valid,
        output In_Ready, Mem_Wr, Mem_Addr, Mem_Data, CPU_Hold, Done, Error, State
    );

    modport master (
        output Load_Req, In_Data, In_Valid,
        input  In_Ready, Mem_Wr, Mem_Addr, Mem_Data, CPU_Hold, Done, Error, State
    );

endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fills the 256 x 16 instruction memory from a framed byte stream:
// count byte, N big-endian words, XOR checksum of the data bytes. Holds the
// processor in reset while loading and on checksum error.
// Ports:
//   clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : imem_loader_if.slave (stream, memory write port, status)
// -----------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
(
    input  logic         clk,
    input  logic         Reset_n,
    imem_loader_if.slave bus
);

    state_t              r_state;
    state_t              w_next;
    logic                r_armed;
    logic [WCNT_W-1:0]   r_count;
    logic [WCNT_W-1:0]   r_words;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [CSUM_W-1:0]   r_csum;

    logic                w_inReady;
    logic                w_accept;
    logic                w_loadGo;
    logic                w_lastWord;

    assign w_inReady  = r_state inside {S_COUNT, S_HI, S_LO, S_CHECK};
    assign w_accept   = bus.In_Valid && w_inReady;
    // r_armed keeps a Load_Req on the first edge after reset release from
    // starting a load.
    assign w_loadGo   = bus.Load_Req && r_armed &&
                        (r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign w_lastWord = (r_words + 9'd1) == r_count;

    // State register.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_loadGo) w_next = S_COUNT;
            S_COUNT: if (w_accept) w_next = S_HI;
            S_HI:    if (w_accept) w_next = S_LO;
            S_LO:    if (w_accept) w_next = S_WRITE;
            S_WRITE: w_next = w_lastWord ? S_CHECK : S_HI;
            S_CHECK: if (w_accept) w_next = (bus.In_Data == r_csum) ? S_DONE : S_ERROR;
            S_DONE:  w_next = w_loadGo ? S_COUNT : S_IDLE;
            S_ERROR: if (w_loadGo) w_next = S_COUNT;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: word count, byte assembler, address counter and checksum.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_armed <= 1'b0;
            r_count <= '0;
            r_words <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_csum  <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_loadGo) begin
                r_addr <= '0;
                r_csum <= '0;
            end
            case (r_state)
                S_COUNT: if (w_accept) begin
                    r_count <= (bus.In_Data == 8'd0) ? WCNT_W'(DEPTH) : {1'b0, bus.In_Data};
                    r_words <= '0;
                end
                S_HI: if (w_accept) begin
                    r_data[15:8] <= bus.In_Data;
                    r_csum       <= r_csum ^ bus.In_Data;
                end
                S_LO: if (w_accept) begin
                    r_data[7:0] <= bus.In_Data;
                    r_csum      <= r_csum ^ bus.In_Data;
                end
                S_WRITE: begin
                    r_addr  <= r_addr + 8'd1;
                    r_words <= r_words + 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Every status output is decoded from the state register alone.
    assign bus.In_Ready = w_inReady;
    assign bus.Mem_Wr   = (r_state == S_WRITE);
    assign bus.Mem_Addr = r_addr;
    assign bus.Mem_Data = r_data;
    assign bus.CPU_Hold = !(r_state inside {S_IDLE, S_DONE});
    assign bus.Done     = (r_state == S_DONE);
    assign bus.Error    = (r_state == S_ERROR);
    assign bus.State    = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: table of load frames with expected end
// status, a write scoreboard fed as words are driven, and hand-written
// sequences for reset release, reset mid-load, full depth and Load_Req spam.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic Reset_n;

    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  cnt;
        int          n;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        bit          bad;
        bit          gaps;
        logic [3:0]  expState;
        logic        expErr;
        logic        expHold;
        int          expDone;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          doneSeen = 0;
    int          writesSeen = 0;
    wr_t         expQ[$];
    logic [15:0] wordBuf [256];
    vec_t        vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every memory write must match the oldest expected word.
    always @(negedge clk) begin
        wr_t e;
        if (Reset_n && bus.Mem_Wr) begin
            writesSeen++;
            checkOutput("inReadyInWrite", {31'd0, bus.In_Ready}, 32'd0);
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedWrite: got write 0x%0h@0x%0h expected none", bus.Mem_Data, bus.Mem_Addr);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrAddr", {24'd0, bus.Mem_Addr}, {24'd0, e.addr});
                checkOutput("wrData", {16'd0, bus.Mem_Data}, {16'd0, e.data});
            end
        end
        if (Reset_n && bus.Done) begin
            doneSeen++;
            checkOutput("holdInDone", {31'd0, bus.CPU_Hold}, 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] b, input bit gaps, input bit spam);
        bit ok = 1'b0;
        if (gaps) begin
            int n = $urandom_range(0, 3);
            repeat (n) begin
                @(negedge clk);
                bus.In_Valid = 1'b0;
                bus.Load_Req = spam;
            end
        end
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            bus.In_Valid = 1'b1;
            bus.In_Data  = b;
            bus.Load_Req = spam;
            if (bus.In_Ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL byteTimeout: byte 0x%0h not accepted, In_Ready=%0b expected 1", b, bus.In_Ready);
        end
    endtask

    task automatic startLoad();
        @(negedge clk);
        bus.Load_Req = 1'b1;
        @(negedge clk);
        bus.Load_Req = 1'b0;
        checkOutput("startState", {28'd0, bus.State}, 32'd1);
        checkOutput("startHold", {31'd0, bus.CPU_Hold}, 32'd1);
        checkOutput("startError", {31'd0, bus.Error}, 32'd0);
    endtask

    task automatic runLoad(input logic [7:0] cnt, input int n, input bit bad, input bit gaps, input bit spam);
        logic [7:0] cs = 8'h00;
        wr_t        e;
        startLoad();
        applyStimulus(cnt, gaps, spam);
        for (int i = 0; i < n; i++) begin
            e.addr = 8'(i);
            e.data = wordBuf[i];
            expQ.push_back(e);
            cs = cs ^ wordBuf[i][15:8] ^ wordBuf[i][7:0];
            applyStimulus(wordBuf[i][15:8], gaps, spam);
            applyStimulus(wordBuf[i][7:0], gaps, spam);
        end
        applyStimulus(bad ? (cs ^ 8'h01) : cs, gaps, spam);
        @(negedge clk);
        bus.In_Valid = 1'b0;
        bus.Load_Req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkEnd(input string tag, input logic [3:0] st, input logic err, input logic hold,
                            input int dDone, input int dWrites, input int expDone, input int expWrites);
        checkOutput({tag, "_state"}, {28'd0, bus.State}, {28'd0, st});
        checkOutput({tag, "_error"}, {31'd0, bus.Error}, {31'd0, err});
        checkOutput({tag, "_hold"}, {31'd0, bus.CPU_Hold}, {31'd0, hold});
        checkOutput({tag, "_done"}, dDone, expDone);
        checkOutput({tag, "_writes"}, dWrites, expWrites);
        checkOutput({tag, "_queue"}, expQ.size(), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        wr_t e;

        vecs[0] = '{8'h02, 2, 16'h1234, 16'hABCD, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h02, 2, 16'h1234, 16'hABCD, 16'h0000, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h01, 1, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1};
        vecs[3] = '{8'h02, 2, 16'h1234, 16'hABCD, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h03, 3, 16'hFFFF, 16'h0001, 16'h8000, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 0};
        vecs[5] = '{8'h03, 3, 16'hFFFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1};

        Reset_n      = 1'b0;
        bus.Load_Req = 1'b0;
        bus.In_Valid = 1'b0;
        bus.In_Data  = 8'h00;
        #23;
        checkOutput("rstState", {28'd0, bus.State}, 32'd0);
        checkOutput("rstInReady", {31'd0, bus.In_Ready}, 32'd0);
        checkOutput("rstMemWr", {31'd0, bus.Mem_Wr}, 32'd0);
        checkOutput("rstMemAddr", {24'd0, bus.Mem_Addr}, 32'd0);
        checkOutput("rstMemData", {16'd0, bus.Mem_Data}, 32'd0);
        checkOutput("rstHold", {31'd0, bus.CPU_Hold}, 32'd0);
        checkOutput("rstDone", {31'd0, bus.Done}, 32'd0);
        checkOutput("rstError", {31'd0, bus.Error}, 32'd0);

        // Load_Req together with reset release must be ignored.
        @(negedge clk);
        Reset_n      = 1'b1;
        bus.Load_Req = 1'b1;
        @(negedge clk);
        bus.Load_Req = 1'b0;
        checkOutput("reqAtRelease", {28'd0, bus.State}, 32'd0);
        repeat (2) @(negedge clk);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            wordBuf[0] = vecs[v].w0;
            wordBuf[1] = vecs[v].w1;
            wordBuf[2] = vecs[v].w2;
            d0 = doneSeen;
            w0 = writesSeen;
            runLoad(vecs[v].cnt, vecs[v].n, vecs[v].bad, vecs[v].gaps, 1'b0);
            checkEnd($sformatf("vec%0d", v), vecs[v].expState, vecs[v].expErr, vecs[v].expHold,
                     doneSeen - d0, writesSeen - w0, vecs[v].expDone, vecs[v].n);
        end

        // Full depth: count byte 0 means 256 words, address wraps back to 0.
        for (int i = 0; i < 256; i++) wordBuf[i] = 16'(i * 16'h0101);
        d0 = doneSeen;
        w0 = writesSeen;
        runLoad(8'h00, 256, 1'b0, 1'b0, 1'b0);
        checkEnd("full", 4'd0, 1'b0, 1'b0, doneSeen - d0, writesSeen - w0, 1, 256);
        checkOutput("fullAddrWrap", {24'd0, bus.Mem_Addr}, 32'd0);

        // Reset in the middle of a load.
        wordBuf[0] = 16'h1234;
        wordBuf[1] = 16'hABCD;
        w0 = writesSeen;
        startLoad();
        applyStimulus(8'h02, 1'b0, 1'b0);
        e.addr = 8'h00;
        e.data = 16'h1234;
        expQ.push_back(e);
        applyStimulus(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b0);
        applyStimulus(8'hAB, 1'b0, 1'b0);
        @(negedge clk);
        bus.In_Valid = 1'b0;
        Reset_n      = 1'b0;
        #1;
        checkOutput("midRstState", {28'd0, bus.State}, 32'd0);
        checkOutput("midRstInReady", {31'd0, bus.In_Ready}, 32'd0);
        checkOutput("midRstMemWr", {31'd0, bus.Mem_Wr}, 32'd0);
        checkOutput("midRstAddr", {24'd0, bus.Mem_Addr}, 32'd0);
        checkOutput("midRstData", {16'd0, bus.Mem_Data}, 32'd0);
        checkOutput("midRstHold", {31'd0, bus.CPU_Hold}, 32'd0);
        checkOutput("midRstError", {31'd0, bus.Error}, 32'd0);
        checkOutput("midRstWrites", writesSeen - w0, 32'd1);
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        d0 = doneSeen;
        w0 = writesSeen;
        runLoad(8'h02, 2, 1'b0, 1'b0, 1'b0);
        checkEnd("afterRst", 4'd0, 1'b0, 1'b0, doneSeen - d0, writesSeen - w0, 1, 2);

        // Load_Req held high through every loading state: no restart.
        d0 = doneSeen;
        w0 = writesSeen;
        runLoad(8'h02, 2, 1'b0, 1'b1, 1'b1);
        checkEnd("spam", 4'd0, 1'b0, 1'b0, doneSeen - d0, writesSeen - w0, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
